dmem_bus_ctrl: RTL and testbench



---
 rtl/dmem_bus_ctrl_if.sv | 38 +++
 rtl/dmem_bus_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dmem_bus_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bus_ctrl_if.sv
// Data-memory bus bundle between the MEM-stage access controller and the
// external data bus. The controller drives the request side (master); the
// memory/bus fabric answers with ack, err and read data (slave).
interface dmem_bus_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [3:0]            bus_sel;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_ack;
  logic                  bus_err;
  logic [DATA_WIDTH-1:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_sel,
    output bus_wdata,
    input  bus_ack,
    input  bus_err,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_sel,
    input  bus_wdata,
    output bus_ack,
    output bus_err,
    output bus_rdata
  );
endinterface

// File: rtl/dmem_bus_ctrl.sv
// Data-memory access controller sitting behind the EX->MEM pipeline register.
// Turns the MEM-stage memory request into a single req/ack bus transaction,
// stalls the pipeline while it is outstanding, returns the raw read word and
// flags bus errors, timeouts and stores with no byte lanes selected.
module dmem_bus_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  global_flush,
  input  logic                  mem_enable_in,
  input  logic                  mem_rw_in,
  input  logic [3:0]            mem_sel_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] mem_write_in,
  output logic [DATA_WIDTH-1:0] mem_read_out,
  output logic                  mem_stall,
  output logic                  mem_err,
  dmem_bus_ctrl_if.master       bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Last WAIT cycle before the transaction is declared timed out.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

  state_t                state_r,   state_s;
  logic [CNT_WIDTH-1:0]  cnt_r,     cnt_s;
  logic                  req_r,     req_s;
  logic                  we_r,      we_s;
  logic [ADDR_WIDTH-1:0] addr_r,    addr_s;
  logic [3:0]            sel_r,     sel_s;
  logic [DATA_WIDTH-1:0] wdata_r,   wdata_s;
  logic [DATA_WIDTH-1:0] rdata_r,   rdata_s;
  logic                  err_r,     err_s;
  logic                  abandon_r, abandon_s;
  logic                  abandon_hit_s;
  logic                  stall_s;
  logic                  unused_addr_lsb_s;

  // Bus addresses are word aligned; the byte offset only matters to the
  // load-extraction logic further down the MEM stage.
  assign unused_addr_lsb_s = ^addr_in[1:0];

  // Next-state, next-output and stall decode for the access FSM.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    req_s         = req_r;
    we_s          = we_r;
    addr_s        = addr_r;
    sel_s         = sel_r;
    wdata_s       = wdata_r;
    rdata_s       = rdata_r;
    err_s         = 1'b0;
    abandon_s     = abandon_r;
    abandon_hit_s = 1'b0;
    stall_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (mem_enable_in && !global_flush) begin
          stall_s   = 1'b1;
          abandon_s = 1'b0;
          if (mem_rw_in && (mem_sel_in == 4'b0000)) begin
            // Store with no lanes: nothing addressable, report it directly.
            state_s = ST_DONE;
            err_s   = 1'b1;
          end else begin
            state_s = ST_WAIT;
            req_s   = 1'b1;
            cnt_s   = CNT_ZERO;
            we_s    = mem_rw_in;
            addr_s  = {addr_in[ADDR_WIDTH-1:2], 2'b00};
            if (mem_rw_in) begin
              sel_s   = mem_sel_in;
              wdata_s = mem_write_in;
            end else begin
              sel_s   = 4'b1111;
              wdata_s = {DATA_WIDTH{1'b0}};
            end
          end
        end else begin
          stall_s = 1'b0;
        end
      end

      ST_WAIT: begin
        stall_s       = 1'b1;
        cnt_s         = cnt_r + CNT_ONE;
        // A flush landing on the ack cycle still abandons this access.
        abandon_hit_s = abandon_r | global_flush;
        if (bus.bus_ack) begin
          state_s   = ST_DONE;
          req_s     = 1'b0;
          err_s     = bus.bus_err & ~abandon_hit_s;
          abandon_s = 1'b0;
          if (!we_r && !abandon_hit_s) begin
            rdata_s = bus.bus_rdata;
          end else begin
            rdata_s = rdata_r;
          end
        end else if (cnt_r == CNT_LAST) begin
          state_s   = ST_DONE;
          req_s     = 1'b0;
          err_s     = ~abandon_hit_s;
          abandon_s = 1'b0;
        end else begin
          abandon_s = abandon_hit_s;
        end
      end

      ST_DONE: begin
        // The instruction still presents its request here; never re-issue.
        state_s   = ST_IDLE;
        abandon_s = 1'b0;
      end

      default: begin
        state_s   = ST_IDLE;
        req_s     = 1'b0;
        abandon_s = 1'b0;
      end
    endcase
  end

  // State and registered-output update; reset drops any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      req_r     <= 1'b0;
      we_r      <= 1'b0;
      addr_r    <= {ADDR_WIDTH{1'b0}};
      sel_r     <= 4'b0000;
      wdata_r   <= {DATA_WIDTH{1'b0}};
      rdata_r   <= {DATA_WIDTH{1'b0}};
      err_r     <= 1'b0;
      abandon_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      req_r     <= req_s;
      we_r      <= we_s;
      addr_r    <= addr_s;
      sel_r     <= sel_s;
      wdata_r   <= wdata_s;
      rdata_r   <= rdata_s;
      err_r     <= err_s;
      abandon_r <= abandon_s;
    end
  end

  // The stall is combinational so the pipeline freezes in the request cycle;
  // it is forced low while reset is held.
  assign mem_stall     = stall_s & ~rst;
  assign mem_err       = err_r;
  assign mem_read_out  = rdata_r;
  assign bus.bus_req   = req_r;
  assign bus.bus_we    = we_r;
  assign bus.bus_addr  = addr_r;
  assign bus.bus_sel   = sel_r;
  assign bus.bus_wdata = wdata_r;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed bench for dmem_bus_ctrl: reads, stores, empty-lane store, timeout,
// flush during WAIT, flush in IDLE, spurious ack and reset during WAIT.
module tb_dmem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        global_flush;
  logic        mem_enable_in;
  logic        mem_rw_in;
  logic [3:0]  mem_sel_in;
  logic [31:0] addr_in;
  logic [31:0] mem_write_in;
  logic [31:0] mem_read_out;
  logic        mem_stall;
  logic        mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Results captured by run_access
  int          st_cnt;
  int          rq_cnt;
  logic        done_seen;
  logic        done_err;
  logic [31:0] done_rd;
  logic [31:0] first_addr;
  logic [3:0]  first_sel;
  logic        first_we;
  logic [31:0] first_wdata;
  logic        unstable;

  dmem_bus_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

  dmem_bus_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16), .CNT_WIDTH(5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .global_flush (global_flush),
    .mem_enable_in(mem_enable_in),
    .mem_rw_in    (mem_rw_in),
    .mem_sel_in   (mem_sel_in),
    .addr_in      (addr_in),
    .mem_write_in (mem_write_in),
    .mem_read_out (mem_read_out),
    .mem_stall    (mem_stall),
    .mem_err      (mem_err),
    .bus          (bus_if)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one access starting just after a rising edge and act as the bus
  // slave. ack_dly = WAIT cycle index of the ack (-1: never); flush_idx = WAIT
  // cycle index on which global_flush pulses (-1: never). Returns just after
  // the rising edge that ends the DONE cycle, enable dropped.
  task automatic run_access(input logic rw, input logic [3:0] sel,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int ack_dly, input logic berr,
                            input logic [31:0] rdata, input int flush_idx);
    int idx;
    idx = 0;
    st_cnt = 0; rq_cnt = 0; done_seen = 1'b0; done_err = 1'b0;
    done_rd = 32'h0; unstable = 1'b0;
    first_addr = 32'h0; first_sel = 4'h0; first_we = 1'b0; first_wdata = 32'h0;
    mem_enable_in = 1'b1; mem_rw_in = rw; mem_sel_in = sel;
    addr_in = addr; mem_write_in = wdata;
    for (int c = 0; c < 64 && !done_seen; c++) begin
      @(negedge clk);
      if (mem_stall) st_cnt++;
      else begin
        done_seen = 1'b1;
        done_err  = mem_err;
        done_rd   = mem_read_out;
      end
      if (bus_if.bus_req) begin
        rq_cnt++;
        if (rq_cnt == 1) begin
          first_addr = bus_if.bus_addr; first_sel = bus_if.bus_sel;
          first_we = bus_if.bus_we; first_wdata = bus_if.bus_wdata;
        end else if (bus_if.bus_addr !== first_addr || bus_if.bus_sel !== first_sel ||
                     bus_if.bus_we !== first_we || bus_if.bus_wdata !== first_wdata) begin
          unstable = 1'b1;
        end
        global_flush     = (idx == flush_idx);
        bus_if.bus_ack   = (idx == ack_dly);
        bus_if.bus_err   = (idx == ack_dly) ? berr : 1'b0;
        bus_if.bus_rdata = (idx == ack_dly) ? rdata : 32'h0BAD_0BAD;
        idx++;
      end else begin
        global_flush   = 1'b0;
        bus_if.bus_ack = 1'b0;
        bus_if.bus_err = 1'b0;
      end
    end
    check_eq("done_reached", 32'(done_seen), 32'h1);
    @(posedge clk);
    #1;
    mem_enable_in = 1'b0;
    global_flush  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; global_flush = 1'b0; mem_enable_in = 1'b0; mem_rw_in = 1'b0;
    mem_sel_in = 4'h0; addr_in = 32'h0; mem_write_in = 32'h0;
    bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0; bus_if.bus_rdata = 32'h0;

    // Reset state
    #12;
    check_eq("rst_req",   32'(bus_if.bus_req), 32'h0);
    check_eq("rst_stall", 32'(mem_stall),      32'h0);
    check_eq("rst_err",   32'(mem_err),        32'h0);
    check_eq("rst_rdata", mem_read_out,        32'h0);
    check_eq("rst_addr",  bus_if.bus_addr,     32'h0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Read, ack in third WAIT cycle
    run_access(1'b0, 4'hF, 32'h0000_1006, 32'h0, 2, 1'b0, 32'hDEAD_BEEF, -1);
    check_eq("rd_addr",   first_addr,         32'h0000_1004);
    check_eq("rd_sel",    32'(first_sel),     32'hF);
    check_eq("rd_we",     32'(first_we),      32'h0);
    check_eq("rd_wdata",  first_wdata,        32'h0);
    check_eq("rd_stall",  32'(st_cnt),        32'd4);
    check_eq("rd_reqcyc", 32'(rq_cnt),        32'd3);
    check_eq("rd_stable", 32'(unstable),      32'h0);
    check_eq("rd_data",   done_rd,            32'hDEAD_BEEF);
    check_eq("rd_err",    32'(done_err),      32'h0);

    // Back-to-back store, immediate ack
    run_access(1'b1, 4'b0011, 32'h0000_2008, 32'h0000_ABCD, 0, 1'b0, 32'h5555_5555, -1);
    check_eq("wr_we",     32'(first_we),      32'h1);
    check_eq("wr_sel",    32'(first_sel),     32'h3);
    check_eq("wr_wdata",  first_wdata,        32'h0000_ABCD);
    check_eq("wr_addr",   first_addr,         32'h0000_2008);
    check_eq("wr_stall",  32'(st_cnt),        32'd2);
    check_eq("wr_reqcyc", 32'(rq_cnt),        32'd1);
    check_eq("wr_err",    32'(done_err),      32'h0);
    check_eq("wr_rdkeep", done_rd,            32'hDEAD_BEEF);

    // Store with no lanes selected
    run_access(1'b1, 4'b0000, 32'h0000_3000, 32'h1111_1111, 0, 1'b0, 32'h0, -1);
    check_eq("mis_reqcyc", 32'(rq_cnt),       32'd0);
    check_eq("mis_stall",  32'(st_cnt),       32'd1);
    check_eq("mis_err",    32'(done_err),     32'h1);
    @(negedge clk);
    check_eq("noreissue_req", 32'(bus_if.bus_req), 32'h0);
    check_eq("err_pulse_end", 32'(mem_err),        32'h0);
    @(posedge clk); #1;

    // Timeout: no ack at all
    run_access(1'b0, 4'hF, 32'h0000_4000, 32'h0, -1, 1'b0, 32'h0, -1);
    check_eq("to_reqcyc", 32'(rq_cnt),        32'd16);
    check_eq("to_stall",  32'(st_cnt),        32'd17);
    check_eq("to_err",    32'(done_err),      32'h1);
    check_eq("to_rdkeep", done_rd,            32'hDEAD_BEEF);

    // Flush during WAIT, then erroring ack with data
    run_access(1'b0, 4'hF, 32'h0000_5000, 32'h0, 3, 1'b1, 32'h1234_5678, 1);
    check_eq("fl_stall",  32'(st_cnt),        32'd5);
    check_eq("fl_reqcyc", 32'(rq_cnt),        32'd4);
    check_eq("fl_err",    32'(done_err),      32'h0);
    check_eq("fl_rdkeep", done_rd,            32'hDEAD_BEEF);

    // Flush in IDLE with a pending request
    mem_enable_in = 1'b1; mem_rw_in = 1'b0; addr_in = 32'h0000_6000; global_flush = 1'b1;
    @(negedge clk);
    check_eq("idlefl_stall", 32'(mem_stall), 32'h0);
    @(negedge clk);
    check_eq("idlefl_req", 32'(bus_if.bus_req), 32'h0);
    mem_enable_in = 1'b0; global_flush = 1'b0;

    // Spurious ack in IDLE
    bus_if.bus_ack = 1'b1; bus_if.bus_err = 1'b1; bus_if.bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0;
    @(negedge clk);
    check_eq("spur_rdata", mem_read_out,       32'hDEAD_BEEF);
    check_eq("spur_err",   32'(mem_err),       32'h0);
    check_eq("spur_req",   32'(bus_if.bus_req),32'h0);

    // Reset in WAIT
    @(posedge clk); #1;
    mem_enable_in = 1'b1; mem_rw_in = 1'b0; addr_in = 32'h0000_7000;
    repeat (3) @(negedge clk);
    check_eq("prerst_req", 32'(bus_if.bus_req), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_req",   32'(bus_if.bus_req), 32'h0);
    check_eq("midrst_addr",  bus_if.bus_addr,     32'h0);
    check_eq("midrst_sel",   32'(bus_if.bus_sel), 32'h0);
    check_eq("midrst_rdata", mem_read_out,        32'h0);
    check_eq("midrst_stall", 32'(mem_stall),      32'h0);
    mem_enable_in = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    run_access(1'b0, 4'hF, 32'h0000_0020, 32'h0, 1, 1'b0, 32'hCAFE_F00D, -1);
    check_eq("post_addr",  first_addr,        32'h0000_0020);
    check_eq("post_stall", 32'(st_cnt),       32'd3);
    check_eq("post_data",  done_rd,           32'hCAFE_F00D);
    check_eq("post_err",   32'(done_err),     32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
